// File: rtl/cdr_loop_filter.sv
// CDR digital loop filter: majority-votes bang-bang phase detector decisions over a
// fixed window, then applies a proportional + integral update to a wrapping phase
// accumulator whose upper bits drive the phase interpolator.
module cdr_loop_filter #(
  parameter int unsigned WIN       = 16,
  parameter int unsigned PI_BITS   = 7,
  parameter int unsigned FRAC_BITS = 4,
  parameter int unsigned FREQ_BITS = 10,
  parameter int unsigned KP        = 16,
  parameter int unsigned KI_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           decision,
  output logic [PI_BITS-1:0]   pi_code,
  output logic                 pi_update,
  output logic [FREQ_BITS-1:0] freq_word
);

  localparam int unsigned SW = $clog2(WIN);
  localparam int unsigned VW = SW + 2;
  localparam int unsigned PW = PI_BITS + FRAC_BITS;
  // Wide enough to sign-extend the frequency word before shifting.
  localparam int unsigned AW = ((PW > FREQ_BITS) ? PW : FREQ_BITS) + 2;

  localparam logic signed [FREQ_BITS-1:0] FreqOne = {{(FREQ_BITS-1){1'b0}}, 1'b1};
  localparam logic signed [FREQ_BITS-1:0] FreqMax = {1'b0, {(FREQ_BITS-1){1'b1}}};
  localparam logic signed [FREQ_BITS-1:0] FreqMin = {1'b1, {(FREQ_BITS-2){1'b0}}, 1'b1};

  localparam logic [1:0] DecLate  = 2'b01;
  localparam logic [1:0] DecEarly = 2'b10;

  logic [SW-1:0]               slot_q, slot_d;
  logic signed [VW-1:0]        vote_q, vote_d;
  logic signed [VW-1:0]        vote_step, vote_sum;
  logic [PW-1:0]               phase_q, phase_d;
  logic signed [FREQ_BITS-1:0] freq_q, freq_d, freq_new;
  logic                        update_q, update_d;
  logic                        win_close;
  logic                        dir_up, dir_dn;
  logic [PW-1:0]               kp_term, ki_term;

  // Vote contribution of the current decision; 2'b11 is treated as no decision.
  always_comb begin
    vote_step = '0;
    case (decision)
      DecEarly: vote_step = {{(VW-1){1'b0}}, 1'b1};
      DecLate:  vote_step = '1;
      default:  vote_step = '0;
    endcase
  end

  // Window-close decode, direction from the final vote, and saturating integrator.
  always_comb begin
    vote_sum  = vote_q + vote_step;
    win_close = en && (slot_q == SW'(WIN - 1));
    dir_dn    = vote_sum[VW-1];
    dir_up    = !vote_sum[VW-1] && (vote_sum != '0);
    freq_new  = freq_q;
    if (dir_up && (freq_q != FreqMax)) begin
      freq_new = freq_q + FreqOne;
    end else if (dir_dn && (freq_q != FreqMin)) begin
      freq_new = freq_q - FreqOne;
    end
  end

  // Phase step terms, computed modulo the accumulator width so wrap is implicit.
  always_comb begin
    kp_term = '0;
    if (dir_up) begin
      kp_term = PW'(KP);
    end else if (dir_dn) begin
      kp_term = '0 - PW'(KP);
    end
    ki_term = PW'($signed({{(AW-FREQ_BITS){freq_new[FREQ_BITS-1]}}, freq_new}) >>> KI_SHIFT);
  end

  // Next-state: accumulate votes per qualified slot, update loop state at window close.
  always_comb begin
    slot_d   = slot_q;
    vote_d   = vote_q;
    phase_d  = phase_q;
    freq_d   = freq_q;
    update_d = 1'b0;
    if (en) begin
      if (win_close) begin
        slot_d   = '0;
        vote_d   = '0;
        freq_d   = freq_new;
        phase_d  = phase_q + kp_term + ki_term;
        update_d = 1'b1;
      end else begin
        slot_d = slot_q + SW'(1);
        vote_d = vote_sum;
      end
    end
  end

  // State registers; synchronous reset discards any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      vote_q   <= '0;
      phase_q  <= '0;
      freq_q   <= '0;
      update_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      vote_q   <= vote_d;
      phase_q  <= phase_d;
      freq_q   <= freq_d;
      update_q <= update_d;
    end
  end

  assign pi_code   = phase_q[PW-1:FRAC_BITS];
  assign freq_word = freq_q;
  assign pi_update = update_q;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Bench for cdr_loop_filter: a default instance and a narrow-integrator instance share
// stimulus; a behavioural model pushes expected window results into per-instance queues.
module tb_cdr_loop_filter;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] decision;
  logic [6:0] code_a, code_b;
  logic       upd_a, upd_b;
  logic [9:0] freq_a;
  logic [3:0] freq_b;

  always #5 clk = ~clk;

  cdr_loop_filter #(.FREQ_BITS(10)) dut_a (
    .clk(clk), .rst(rst), .en(en), .decision(decision),
    .pi_code(code_a), .pi_update(upd_a), .freq_word(freq_a)
  );

  cdr_loop_filter #(.FREQ_BITS(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .decision(decision),
    .pi_code(code_b), .pi_update(upd_b), .freq_word(freq_b)
  );

  typedef struct {int code; int freq;} exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int m_vote[2], m_slot[2], m_freq[2], m_phase[2];
  int cur_code[2], cur_freq[2];
  int pulses[2];
  bit pend[2];
  bit eu0 = 1'b0, eu1 = 1'b0;
  bit rst_s = 1'b1;

  // Drive one cycle of inputs and advance the model with the same values.
  task automatic drive(input bit r, input bit e, input logic [1:0] d);
    int dir, nf, fmax, fb;
    exp_t x;
    rst = r; en = e; decision = d;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0;
      fb = (i == 0) ? 10 : 4;
      if (r) begin
        m_vote[i] = 0; m_slot[i] = 0; m_freq[i] = 0; m_phase[i] = 0;
      end else if (e) begin
        if (d == 2'b10) m_vote[i]++;
        else if (d == 2'b01) m_vote[i]--;
        if (m_slot[i] == 15) begin
          dir  = (m_vote[i] > 0) ? 1 : (m_vote[i] < 0) ? -1 : 0;
          fmax = (1 << (fb - 1)) - 1;
          nf   = m_freq[i] + dir;
          if (nf > fmax) nf = fmax;
          if (nf < -fmax) nf = -fmax;
          m_freq[i]  = nf;
          m_phase[i] = (m_phase[i] + dir * 16 + (nf >>> 2)) & 2047;
          x.code = m_phase[i] >> 4;
          x.freq = m_freq[i];
          if (i == 0) q_a.push_back(x);
          else q_b.push_back(x);
          pend[i]   = 1'b1;
          m_slot[i] = 0;
          m_vote[i] = 0;
        end else begin
          m_slot[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b1, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b0, 2'b00);
  endtask

  // Expected pulse and reset status for the edge the DUT is sampling.
  always @(posedge clk) begin
    rst_s <= rst;
    eu0   <= pend[0];
    eu1   <= pend[1];
  end

  // Per-cycle scoreboard: pulse timing, popped window results, hold between pulses.
  always @(negedge clk) begin
    logic        u;
    logic [31:0] oc, ofr;
    bit          eu;
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      u   = (i == 0) ? upd_a : upd_b;
      oc  = (i == 0) ? {25'd0, code_a} : {25'd0, code_b};
      ofr = (i == 0) ? {{22{freq_a[9]}}, freq_a} : {{28{freq_b[3]}}, freq_b};
      eu  = (i == 0) ? eu0 : eu1;
      if (rst_s) begin
        cur_code[i] = 0;
        cur_freq[i] = 0;
      end
      checks++;
      if (u !== eu) begin
        errors++;
        $display("FAIL pulse dut%0d t=%0t got %b want %b", i, $time, u, eu);
      end
      if (eu) begin
        pulses[i]++;
        if (i == 0 && q_a.size() > 0) begin
          e = q_a.pop_front();
          cur_code[i] = e.code; cur_freq[i] = e.freq;
        end else if (i == 1 && q_b.size() > 0) begin
          e = q_b.pop_front();
          cur_code[i] = e.code; cur_freq[i] = e.freq;
        end else begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty dut%0d t=%0t got pulse want none queued", i, $time);
        end
      end
      checks++;
      if (oc !== 32'(cur_code[i]) || ofr !== 32'(cur_freq[i])) begin
        errors++;
        $display("FAIL outputs dut%0d t=%0t got code %0d freq %0h want code %0d freq %0h",
                 i, $time, oc, ofr, cur_code[i], 32'(cur_freq[i]));
      end
    end
  end

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 2'b10);
      checks++;
      if (code_a !== 7'd0 || freq_a !== 10'd0 || upd_a !== 1'b0) begin
        errors++;
        $display("FAIL reset got code %0d freq %0d upd %b want 0 0 0", code_a, freq_a, upd_a);
      end
    end
  endtask

  task automatic test_single_early();
    int p0;
    apply_reset();
    p0 = pulses[0];
    for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b0, 2'b00);
    checks++;
    if (code_a !== 7'd1 || freq_a !== 10'd1 || pulses[0] - p0 != 1) begin
      errors++;
      $display("FAIL single_early got code %0d freq %0d pulses %0d want 1 1 1",
               code_a, freq_a, pulses[0] - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    apply_reset();
    p0 = pulses[0];
    for (int k = 0; k < 64; k++) drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b0, 2'b00);
    checks++;
    if (code_a !== 7'd4 || freq_a !== 10'd4 || pulses[0] - p0 != 4) begin
      errors++;
      $display("FAIL back_to_back got code %0d freq %0d pulses %0d want 4 4 4",
               code_a, freq_a, pulses[0] - p0);
    end
  endtask

  task automatic test_late_wrap();
    apply_reset();
    for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b0, 2'b00);
    checks++;
    if (code_a !== 7'd126 || freq_a !== 10'h3FF) begin
      errors++;
      $display("FAIL late_wrap got code %0d freq %0h want 126 3ff", code_a, freq_a);
    end
  endtask

  task automatic test_balanced_gapped();
    int p0;
    apply_reset();
    p0 = pulses[0];
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k % 3 == 0) drive(1'b0, 1'b0, 2'b10);
      if (k % 5 == 0) drive(1'b0, 1'b0, 2'b11);
    end
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, (k < 7) ? 2'b10 : (k < 14) ? 2'b01 : 2'b11);
      if (k % 4 == 1) drive(1'b0, 1'b0, 2'b01);
    end
    drive(1'b0, 1'b0, 2'b00);
    checks++;
    if (code_a !== 7'd0 || freq_a !== 10'd0 || pulses[0] - p0 != 2) begin
      errors++;
      $display("FAIL balanced got code %0d freq %0d pulses %0d want 0 0 2",
               code_a, freq_a, pulses[0] - p0);
    end
  endtask

  task automatic test_reset_mid_window();
    int p0;
    apply_reset();
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 2'b10);
    drive(1'b1, 1'b1, 2'b10);
    p0 = pulses[0];
    for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b0, 2'b00);
    checks++;
    if (code_a !== 7'd1 || freq_a !== 10'd1 || pulses[0] - p0 != 1) begin
      errors++;
      $display("FAIL reset_mid got code %0d freq %0d pulses %0d want 1 1 1",
               code_a, freq_a, pulses[0] - p0);
    end
  endtask

  task automatic test_saturation();
    int p1;
    apply_reset();
    p1 = pulses[1];
    for (int k = 0; k < 160; k++) drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b0, 2'b00);
    checks++;
    if (freq_b !== 4'd7 || code_b !== 7'd10 || pulses[1] - p1 != 10) begin
      errors++;
      $display("FAIL saturation got freq %0d code %0d pulses %0d want 7 10 10",
               freq_b, code_b, pulses[1] - p1);
    end
    checks++;
    if (freq_a !== 10'd10) begin
      errors++;
      $display("FAIL unsaturated got freq %0d want 10", freq_a);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; decision = 2'b00;
    test_reset();
    test_single_early();
    test_back_to_back();
    test_late_wrap();
    test_balanced_gapped();
    test_reset_mid_window();
    test_saturation();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d/%0d queued want 0/0", q_a.size(), q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
